ppi_sequencer: RTL
==================

PPI_SEQUENCER -- requirements
Module: ppi_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 2560: samples per PPI frame; legal range 16..4096.
REQ-002 Parameter PIPE_DELAY, default 4: ADC pipeline latency in samples; legal range 1..15.
REQ-003 Parameter GAP_CYCLES, default 7: framesync low time between frames, in CLK25M cycles; legal range 1..63.
REQ-004 CLK25M  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 PPI_Enable  in  1  acquisition request level from the DSP.
REQ-007 sample_tick  in  1  one-cycle pulse per ADC sample, already synchronous to CLK25M.
REQ-008 framesync  out  1  PPI frame sync, high while a frame is in progress.
REQ-009 start_PPI  out  1  high in every state except IDLE and PIPE_WAIT.
REQ-010 sample_idx  out  12  index of the current sample within the frame.
REQ-011 seq_tag  out  3  equals sample_idx[2:0]; feeds data bits 15:13.
REQ-012 node_mark  out  1  equals framesync AND (sample_idx[7:0]==0); feeds data bit 12.
REQ-013 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-014 frame_cnt  out  8  count of completed frames; wraps from 255 to 0.
REQ-015 stop_pending  out  1  high when PPI_Enable has fallen during an active frame.
REQ-016 LED7  out  1  equals start_PPI.

Function
REQ-017 The block SHALL implement a registered FSM with states IDLE, PIPE_WAIT, ACTIVE and GAP; all outputs SHALL be registered or decoded from registers only.
REQ-018 IDLE: when PPI_Enable=1 is sampled, go to PIPE_WAIT and clear the delay counter; otherwise remain in IDLE.
REQ-019 PIPE_WAIT: each sample_tick SHALL increment the delay counter.
REQ-020 PIPE_WAIT: the cycle after the PIPE_DELAY-th tick is sampled, the FSM SHALL enter ACTIVE with framesync=1 and sample_idx=0.
REQ-021 PIPE_WAIT: if PPI_Enable=0 is sampled, the FSM SHALL return to IDLE; this takes priority over a coincident final tick.
REQ-022 ACTIVE: a sample_tick on the cycle ACTIVE is entered SHALL be ignored; counting starts on the next cycle.
REQ-023 ACTIVE: each later sample_tick SHALL increment sample_idx by 1.
REQ-024 ACTIVE: on a sample_tick with sample_idx==FRAME_LEN-1, the next cycle SHALL have framesync=0, sample_idx=0 and frame_done=1 for one cycle; frame_cnt SHALL increment and the FSM SHALL enter GAP.
REQ-025 ACTIVE: PPI_Enable falling SHALL set stop_pending; the frame SHALL NOT be truncated.
REQ-026 GAP: framesync SHALL stay 0 for exactly GAP_CYCLES cycles.
REQ-027 GAP: sample_tick SHALL be ignored (this is the known dropped sample).
REQ-028 GAP exit: if PPI_Enable=1 and stop_pending=0 on the last GAP cycle, enter ACTIVE (framesync=1, sample_idx=0); otherwise enter IDLE and clear stop_pending.
REQ-029 A PPI_Enable re-assertion after stop_pending is set SHALL NOT clear stop_pending; a restart SHALL pass through IDLE and PIPE_WAIT again.
REQ-030 start_PPI SHALL rise in the same cycle framesync first rises, and SHALL fall in the cycle the FSM enters IDLE.
REQ-031 sample_idx SHALL never exceed FRAME_LEN-1; frame_cnt wrap-around SHALL NOT affect any other output.

Reset
REQ-032 RST=1 SHALL force, on the next edge: state IDLE; framesync, start_PPI, LED7, frame_done, stop_pending = 0; sample_idx, seq_tag, frame_cnt and the delay counter = 0.
REQ-033 RST SHALL override every other input in any state, including mid-frame and mid-GAP; no frame_done SHALL be emitted for an aborted frame.
REQ-034 After RST falls, the FSM SHALL remain in IDLE until PPI_Enable=1 is sampled.

Verification (FRAME_LEN=16, PIPE_DELAY=4, GAP_CYCLES=7, sample_tick every 10 cycles)
REQ-035 Start: PPI_Enable=1 held -> framesync and start_PPI rise 1 cycle after the 4th tick; node_mark=1 at idx 0; seq_tag runs 0..7,0..7.
REQ-036 Frame wrap: the 16th counted tick -> frame_done pulse, framesync low exactly 7 cycles, next frame restarts at idx 0 with frame_cnt=1.
REQ-037 Stop mid-frame: PPI_Enable drops at idx 5 -> stop_pending=1, frame finishes at idx 15, GAP, then IDLE with start_PPI=0 and frame_cnt=1.
REQ-038 Abort in PIPE_WAIT: PPI_Enable drops after 2 ticks -> IDLE, framesync never rises; re-enable -> a full 4-tick wait is required again.
REQ-039 Reset mid-frame: RST at idx 9 -> all outputs 0 next cycle, no frame_done; restart behaves as in REQ-035.
REQ-040 Wrap/coincidence: run 256 frames -> frame_cnt wraps 255->0; a tick coincident with entry into ACTIVE is not counted.

Source files
------------

// File: rtl/ppi_sequencer.sv
// PPI frame sequencer: waits out the ADC pipeline, frames FRAME_LEN samples, then holds a GAP before the next frame.
// Outputs are registered and respond one cycle after the sampled input; there is no backpressure, and sample_tick pulses are consumed or dropped.
module ppi_sequencer #(
  parameter int FRAME_LEN  = 2560,
  parameter int PIPE_DELAY = 4,
  parameter int GAP_CYCLES = 7
) (
  input  logic        CLK25M,
  input  logic        RST,
  input  logic        PPI_Enable,
  input  logic        sample_tick,
  output logic        framesync,
  output logic        start_PPI,
  output logic [11:0] sample_idx,
  output logic [2:0]  seq_tag,
  output logic        node_mark,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        stop_pending,
  output logic        LED7
);

  localparam logic [11:0] IDX_LAST = 12'(FRAME_LEN - 1);
  localparam logic [3:0]  DLY_LAST = 4'(PIPE_DELAY - 1);
  localparam logic [5:0]  GAP_LAST = 6'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PIPE_WAIT, ACTIVE, GAP} state_t;

  state_t      state;
  logic [3:0]  dly_cnt;
  logic [5:0]  gap_cnt;
  logic        entry_cyc;

  always_ff @(posedge CLK25M) begin
    if (RST) begin
      state        <= IDLE;
      dly_cnt      <= 4'd0;
      gap_cnt      <= 6'd0;
      entry_cyc    <= 1'b0;
      framesync    <= 1'b0;
      start_PPI    <= 1'b0;
      sample_idx   <= 12'd0;
      frame_done   <= 1'b0;
      frame_cnt    <= 8'd0;
      stop_pending <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      entry_cyc  <= 1'b0;
      case (state)
        IDLE: begin
          if (PPI_Enable) begin
            state   <= PIPE_WAIT;
            dly_cnt <= 4'd0;
          end
        end
        PIPE_WAIT: begin
          // A dropped enable wins over a coincident final pipeline tick.
          if (!PPI_Enable) begin
            state <= IDLE;
          end else if (sample_tick) begin
            if (dly_cnt == DLY_LAST) begin
              state      <= ACTIVE;
              framesync  <= 1'b1;
              start_PPI  <= 1'b1;
              sample_idx <= 12'd0;
              entry_cyc  <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt + 4'd1;
            end
          end
        end
        ACTIVE: begin
          if (!PPI_Enable) stop_pending <= 1'b1;
          // The tick landing on the entry cycle belongs to no sample slot.
          if (sample_tick && !entry_cyc) begin
            if (sample_idx == IDX_LAST) begin
              state      <= GAP;
              gap_cnt    <= 6'd0;
              framesync  <= 1'b0;
              sample_idx <= 12'd0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
            end else begin
              sample_idx <= sample_idx + 12'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (PPI_Enable && !stop_pending) begin
              state      <= ACTIVE;
              framesync  <= 1'b1;
              sample_idx <= 12'd0;
              entry_cyc  <= 1'b1;
            end else begin
              state        <= IDLE;
              start_PPI    <= 1'b0;
              stop_pending <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign seq_tag   = sample_idx[2:0];
  assign node_mark = framesync & (sample_idx[7:0] == 8'd0);
  assign LED7      = start_PPI;

endmodule
